// File: rtl/strobe_sched_pkg.sv
// strobe_sched_pkg: shared FSM state type and timestamp width for strobe_scheduler
package strobe_sched_pkg;
    localparam int TS_W = 32;
    typedef enum logic [1:0] {IDLE, SETTLE, PULSE, HOLD} state_t;
endpackage

// File: rtl/strobe_scheduler_if.sv
// strobe_scheduler_if: requester/measurement-side bundle of strobe_scheduler
// en, req, ovf_clr: controls and requests into the scheduler
// sel, strobe, busy, ack, ovf: scheduler outputs; ts added when STROBE_SCHED_TIMESTAMP_EN is defined
interface strobe_scheduler_if #(parameter int N_CH = 4);
    import strobe_sched_pkg::*;
    localparam int SW = $clog2(N_CH);
    logic            en;
    logic [N_CH-1:0] req;
    logic            ovf_clr;
    logic [SW-1:0]   sel;
    logic            strobe;
    logic            busy;
    logic [N_CH-1:0] ack;
    logic [N_CH-1:0] ovf;
`ifdef STROBE_SCHED_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
    modport master (output en, req, ovf_clr, input sel, strobe, busy, ack, ovf, ts);
    modport slave (input en, req, ovf_clr, output sel, strobe, busy, ack, ovf, ts);
`else
    modport master (output en, req, ovf_clr, input sel, strobe, busy, ack, ovf);
    modport slave (input en, req, ovf_clr, output sel, strobe, busy, ack, ovf);
`endif
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past the last winner
// pending: request vector; last: previous winner; gnt_valid/gnt_idx: chosen channel
module rr_arbiter #(
    parameter int N_CH = 4,
    localparam int SW = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] pending,
    input  logic [SW-1:0]   last,
    output logic            gnt_valid,
    output logic [SW-1:0]   gnt_idx
);
    logic [SW-1:0] j;
    // Scan from the farthest offset down so the nearest pending channel after last wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx = last;
        j = last;
        for (int k = N_CH; k >= 1; k--) begin
            j = SW'((int'(last) + k) % N_CH);
            if (pending[j]) begin
                gnt_valid = 1'b1;
                gnt_idx = j;
            end
        end
    end
endmodule

// File: rtl/strobe_scheduler.sv
// strobe_scheduler: round-robin time-sharing of one strobe/measurement unit among N_CH requesters
// clk, rst: clock and synchronous active-high reset; bus: strobe_scheduler_if slave port
// Optional STROBE_SCHED_TIMESTAMP_EN adds a free-running cycle counter captured into bus.ts at strobe rise
module strobe_scheduler import strobe_sched_pkg::*; #(
    parameter int N_CH = 4,
    parameter int SETTLE_CYC = 2,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC = 1,
    parameter int CW = 8
) (
    input logic clk,
    input logic rst,
    strobe_scheduler_if.slave bus
);
    localparam int SW = $clog2(N_CH);
    state_t state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [N_CH-1:0] pending, pending_n, clr, ovf_n;
    logic [SW-1:0]   last, last_n, sel_n, gnt_idx;
    logic            strobe_n, gnt_valid;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .pending(pending),
        .last(last),
        .gnt_valid(gnt_valid),
        .gnt_idx(gnt_idx)
    );

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        sel_n = bus.sel;
        last_n = last;
        strobe_n = bus.strobe;
        clr = '0;
        case (state)
            IDLE: if (bus.en && gnt_valid) begin
                state_n = SETTLE;
                cnt_n = CW'(SETTLE_CYC - 1);
                sel_n = gnt_idx;
                last_n = gnt_idx;
            end
            SETTLE: if (cnt == '0) begin
                state_n = PULSE;
                cnt_n = CW'(PULSE_CYC - 1);
                strobe_n = 1'b1;
            end else cnt_n = cnt - CW'(1);
            PULSE: if (cnt == '0) begin
                state_n = HOLD;
                cnt_n = CW'(HOLD_CYC - 1);
                strobe_n = 1'b0;
            end else cnt_n = cnt - CW'(1);
            HOLD: if (cnt == '0) begin
                state_n = IDLE;
                clr = N_CH'(1) << bus.sel;
            end else cnt_n = cnt - CW'(1);
            default: state_n = IDLE;
        endcase
        // A new request on the clearing edge re-arms pending rather than counting as lost.
        pending_n = (pending & ~clr) | bus.req;
        ovf_n = (bus.ovf & ~{N_CH{bus.ovf_clr}}) | (bus.req & pending & ~clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            pending <= '0;
            last <= SW'(N_CH - 1);
            bus.sel <= '0;
            bus.strobe <= 1'b0;
            bus.busy <= 1'b0;
            bus.ack <= '0;
            bus.ovf <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            pending <= pending_n;
            last <= last_n;
            bus.sel <= sel_n;
            bus.strobe <= strobe_n;
            bus.busy <= (state_n != IDLE);
            bus.ack <= clr;
            bus.ovf <= ovf_n;
        end
    end

`ifdef STROBE_SCHED_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt <= '0;
            bus.ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (state == SETTLE && cnt == '0) bus.ts <= ts_cnt;
        end
    end
`else
    // No timestamp hardware in this build.
`endif
endmodule

// File: tb/tb_strobe_scheduler.sv
// tb_strobe_scheduler: scoreboard-based self-checking bench for strobe_scheduler (defaults S=2, P=1, H=1)
module tb_strobe_scheduler;
    import strobe_sched_pkg::*;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    strobe_scheduler_if #(.N_CH(N)) bus();
    strobe_scheduler #(.N_CH(N), .SETTLE_CYC(2), .PULSE_CYC(1), .HOLD_CYC(1), .CW(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];

    // Every ack pulse is matched against the oldest expected channel.
    always @(negedge clk) begin
        if (!rst && bus.ack !== '0) begin : pop
            int c;
            if (exp_q.size() == 0) begin
                $display("FAIL ack_unexpected: got %b, expected none", bus.ack);
                miscompares++;
            end else begin
                c = exp_q.pop_front();
                if (bus.ack !== 4'(1 << c)) begin
                    $display("FAIL ack_scoreboard: got %b, expected %b", bus.ack, 4'(1 << c));
                    miscompares++;
                end
            end
            vectors++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.en = 1'b1;
        bus.ovf_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.en = 1'b1;
        bus.ovf_clr = 1'b0;
        tick();
        tick();
        if (bus.sel !== 2'd0) begin $display("FAIL reset_sel: got %0d, expected 0", bus.sel); miscompares++; end
        vectors++;
        if (bus.strobe !== 1'b0) begin $display("FAIL reset_strobe: got %b, expected 0", bus.strobe); miscompares++; end
        vectors++;
        if (bus.busy !== 1'b0) begin $display("FAIL reset_busy: got %b, expected 0", bus.busy); miscompares++; end
        vectors++;
        if (bus.ack !== 4'b0) begin $display("FAIL reset_ack: got %b, expected 0000", bus.ack); miscompares++; end
        vectors++;
        if (bus.ovf !== 4'b0) begin $display("FAIL reset_ovf: got %b, expected 0000", bus.ovf); miscompares++; end
        vectors++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        bus.req = 4'b0100;
        exp_q.push_back(2);
        tick();
        bus.req = '0;
        if (bus.busy !== 1'b0) begin $display("FAIL single_busy_e0: got %b, expected 0", bus.busy); miscompares++; end
        vectors++;
        tick();
        if (bus.busy !== 1'b1) begin $display("FAIL single_busy_e1: got %b, expected 1", bus.busy); miscompares++; end
        vectors++;
        if (bus.sel !== 2'd2) begin $display("FAIL single_sel_e1: got %0d, expected 2", bus.sel); miscompares++; end
        vectors++;
        tick();
        if (bus.strobe !== 1'b0) begin $display("FAIL single_strobe_e2: got %b, expected 0", bus.strobe); miscompares++; end
        vectors++;
        tick();
        if (bus.strobe !== 1'b1) begin $display("FAIL single_strobe_e3: got %b, expected 1", bus.strobe); miscompares++; end
        vectors++;
`ifdef STROBE_SCHED_TIMESTAMP_EN
        if (bus.ts !== 32'd3) begin $display("FAIL single_ts: got %0d, expected 3", bus.ts); miscompares++; end
        vectors++;
`endif
        tick();
        if (bus.strobe !== 1'b0) begin $display("FAIL single_strobe_e4: got %b, expected 0", bus.strobe); miscompares++; end
        vectors++;
        if (bus.busy !== 1'b1) begin $display("FAIL single_busy_e4: got %b, expected 1", bus.busy); miscompares++; end
        vectors++;
        tick();
        if (bus.ack !== 4'b0100) begin $display("FAIL single_ack_e5: got %b, expected 0100", bus.ack); miscompares++; end
        vectors++;
        if (bus.busy !== 1'b0) begin $display("FAIL single_busy_e5: got %b, expected 0", bus.busy); miscompares++; end
        vectors++;
        tick();
        if (bus.ack !== 4'b0) begin $display("FAIL single_ack_e6: got %b, expected 0000", bus.ack); miscompares++; end
        vectors++;
    endtask

    task automatic test_multi();
        int rises[$];
        int sels[$];
        int exp_r[3] = '{3, 8, 13};
        int exp_s[3] = '{0, 1, 3};
        logic prev;
        apply_reset();
        bus.req = 4'b1011;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(3);
        tick();
        bus.req = '0;
        prev = 1'b0;
        for (int t = 1; t <= 25; t++) begin
            tick();
            if (bus.strobe && !prev) begin
                rises.push_back(t);
                sels.push_back(int'(bus.sel));
            end
            prev = bus.strobe;
        end
        if (rises.size() !== 3) begin $display("FAIL multi_strobe_count: got %0d, expected 3", rises.size()); miscompares++; end
        vectors++;
        for (int i = 0; i < 3 && i < rises.size(); i++) begin
            if (rises[i] !== exp_r[i]) begin $display("FAIL multi_rise%0d: got edge %0d, expected %0d", i, rises[i], exp_r[i]); miscompares++; end
            vectors++;
            if (sels[i] !== exp_s[i]) begin $display("FAIL multi_sel%0d: got %0d, expected %0d", i, sels[i], exp_s[i]); miscompares++; end
            vectors++;
        end
        if (exp_q.size() !== 0) begin $display("FAIL multi_drain: got %0d outstanding, expected 0", exp_q.size()); miscompares++; end
        vectors++;
    endtask

    task automatic test_fairness();
        int grants[$];
        int exp_g[4] = '{0, 1, 0, 1};
        int reposts;
        logic prev_busy;
        apply_reset();
        bus.req = 4'b0011;
        exp_q.push_back(0);
        exp_q.push_back(1);
        tick();
        bus.req = '0;
        reposts = 0;
        prev_busy = 1'b0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (bus.busy && !prev_busy) grants.push_back(int'(bus.sel));
            prev_busy = bus.busy;
            bus.req = '0;
            if (bus.ack !== '0 && reposts < 2) begin
                bus.req = bus.ack;
                exp_q.push_back(bus.ack[0] ? 0 : 1);
                reposts++;
            end
        end
        bus.req = '0;
        if (grants.size() !== 4) begin $display("FAIL fair_count: got %0d, expected 4", grants.size()); miscompares++; end
        vectors++;
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            if (grants[i] !== exp_g[i]) begin $display("FAIL fair_grant%0d: got %0d, expected %0d", i, grants[i], exp_g[i]); miscompares++; end
            vectors++;
        end
        if (exp_q.size() !== 0) begin $display("FAIL fair_drain: got %0d outstanding, expected 0", exp_q.size()); miscompares++; end
        vectors++;
    endtask

    task automatic test_overflow();
        int seen_busy;
        apply_reset();
        bus.req = 4'b0010;
        exp_q.push_back(1);
        tick();
        bus.req = '0;
        tick();
        bus.req = 4'b0010;
        tick();
        bus.req = '0;
        if (bus.ovf !== 4'b0010) begin $display("FAIL ovf_set: got %b, expected 0010", bus.ovf); miscompares++; end
        vectors++;
        tick();
        tick();
        tick();
        if (bus.ack !== 4'b0010) begin $display("FAIL ovf_ack: got %b, expected 0010", bus.ack); miscompares++; end
        vectors++;
        seen_busy = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (bus.busy) seen_busy++;
        end
        if (seen_busy !== 0) begin $display("FAIL ovf_single_grant: got %0d busy cycles, expected 0", seen_busy); miscompares++; end
        vectors++;
        if (bus.ovf !== 4'b0010) begin $display("FAIL ovf_sticky: got %b, expected 0010", bus.ovf); miscompares++; end
        vectors++;
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        if (bus.ovf !== 4'b0) begin $display("FAIL ovf_clr: got %b, expected 0000", bus.ovf); miscompares++; end
        vectors++;
        bus.req = 4'b0010;
        exp_q.push_back(1);
        tick();
        bus.req = '0;
        tick();
        tick();
        tick();
        tick();
        bus.req = 4'b0010;
        exp_q.push_back(1);
        tick();
        bus.req = '0;
        if (bus.ack !== 4'b0010) begin $display("FAIL ackedge_ack: got %b, expected 0010", bus.ack); miscompares++; end
        vectors++;
        if (bus.ovf !== 4'b0) begin $display("FAIL ackedge_ovf: got %b, expected 0000", bus.ovf); miscompares++; end
        vectors++;
        tick();
        if (bus.busy !== 1'b1 || bus.sel !== 2'd1) begin $display("FAIL ackedge_regrant: got busy=%b sel=%0d, expected busy=1 sel=1", bus.busy, bus.sel); miscompares++; end
        vectors++;
        for (int t = 0; t < 5; t++) tick();
        if (exp_q.size() !== 0) begin $display("FAIL ackedge_drain: got %0d outstanding, expected 0", exp_q.size()); miscompares++; end
        vectors++;
    endtask

    task automatic test_reset_mid();
        int seen_busy;
        apply_reset();
        bus.req = 4'b0011;
        tick();
        bus.req = '0;
        tick();
        tick();
        tick();
        if (bus.strobe !== 1'b1) begin $display("FAIL rstmid_in_pulse: got strobe=%b, expected 1", bus.strobe); miscompares++; end
        vectors++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (bus.strobe !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== 4'b0) begin
            $display("FAIL rstmid_outputs: got strobe=%b busy=%b ack=%b, expected 0 0 0000", bus.strobe, bus.busy, bus.ack);
            miscompares++;
        end
        vectors++;
        seen_busy = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (bus.busy) seen_busy++;
        end
        if (seen_busy !== 0) begin $display("FAIL rstmid_pending: got %0d busy cycles, expected 0", seen_busy); miscompares++; end
        vectors++;
    endtask

    task automatic test_enable();
        int seen_busy;
        apply_reset();
        bus.en = 1'b0;
        bus.req = 4'b1000;
        exp_q.push_back(3);
        tick();
        bus.req = '0;
        seen_busy = 0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (bus.busy) seen_busy++;
        end
        if (seen_busy !== 0) begin $display("FAIL en_hold: got %0d busy cycles, expected 0", seen_busy); miscompares++; end
        vectors++;
        bus.en = 1'b1;
        tick();
        if (bus.busy !== 1'b1 || bus.sel !== 2'd3) begin $display("FAIL en_grant: got busy=%b sel=%0d, expected busy=1 sel=3", bus.busy, bus.sel); miscompares++; end
        vectors++;
        bus.en = 1'b0;
        bus.req = 4'b0001;
        exp_q.push_back(0);
        tick();
        bus.req = '0;
        tick();
        tick();
        tick();
        if (bus.ack !== 4'b1000) begin $display("FAIL en_complete: got %b, expected 1000", bus.ack); miscompares++; end
        vectors++;
        seen_busy = 0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (bus.busy) seen_busy++;
        end
        if (seen_busy !== 0) begin $display("FAIL en_low_idle: got %0d busy cycles, expected 0", seen_busy); miscompares++; end
        vectors++;
        bus.en = 1'b1;
        tick();
        if (bus.busy !== 1'b1 || bus.sel !== 2'd0) begin $display("FAIL en_latched: got busy=%b sel=%0d, expected busy=1 sel=0", bus.busy, bus.sel); miscompares++; end
        vectors++;
        for (int t = 0; t < 5; t++) tick();
        if (exp_q.size() !== 0) begin $display("FAIL en_drain: got %0d outstanding, expected 0", exp_q.size()); miscompares++; end
        vectors++;
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b1;
        bus.req = '0;
        bus.ovf_clr = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_fairness();
        test_overflow();
        test_reset_mid();
        test_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/strobe_scheduler.md
# strobe_scheduler

Time-shares one `strobe` measurement/dump unit among `N_CH` requesters. Each requester posts a one-cycle request. The scheduler grants requests round-robin, drives the channel select, waits for the selected analog/PWL node to settle, fires a strobe pulse, then acknowledges. It sits between the testbench measurement controllers and the channel mux that feeds the `strobe` module's `in`, and it drives that module's `strobe` input.

## Interface
- `N_CH`, 4: number of requesters, ≥2.
- `SETTLE_CYC`, 2: cycles between a select change and strobe rise, ≥1.
- `PULSE_CYC`, 1: strobe high width in cycles, ≥1.
- `HOLD_CYC`, 1: cycles after strobe fall before ack and release, ≥1.
- `CW`, 8: width of the internal phase counter; must hold max(SETTLE_CYC, PULSE_CYC, HOLD_CYC).

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  when low, no new grant starts; an in-flight grant completes.
- `req`  in  N_CH  one-cycle request pulses, one bit per channel.
- `ovf_clr`  in  1  clears all `ovf` bits.
- `sel`  out  $clog2(N_CH)  channel select to the measurement mux.
- `strobe`  out  1  strobe to the measurement unit.
- `busy`  out  1  high from grant until ack.
- `ack`  out  N_CH  one-cycle completion pulse, one-hot.
- `ovf`  out  N_CH  sticky flag: a request was lost on this channel.

## Operation
- `pending[i]` is set on any edge where `req[i]`=1.
- `pending[i]` is cleared on the edge that asserts `ack[i]`.
  - If `req[i]` is also high on that same edge, set wins: `pending` stays 1 and `ovf` is not set.
- If `req[i]`=1 while `pending[i]`=1 and no clear happens on that edge, then `ovf[i]` is set. It stays set until `ovf_clr` or `rst`. If `ovf_clr` and a new overflow occur on the same edge, the set wins.
- State machine: IDLE → SETTLE → PULSE → HOLD → IDLE.
  - IDLE: if `en` and `pending`≠0, pick the winner, load `sel`, set the counter to SETTLE_CYC-1, and go to SETTLE.
  - SETTLE: when the counter reaches 0, go to PULSE. The counter reloads with PULSE_CYC-1 and `strobe` is registered to 1.
  - PULSE: when the counter reaches 0, go to HOLD. The counter reloads with HOLD_CYC-1 and `strobe` is cleared.
  - HOLD: when the counter reaches 0, go to IDLE, pulse `ack[sel]`, and clear `pending[sel]`.
- Round-robin arbitration:
  - Search starts at `last+1` modulo N_CH.
  - `last` updates at grant.
  - After reset, `last`=N_CH-1, so channel 0 has first priority.
- `sel` holds its value from grant through ack and keeps the last value in IDLE.
- The winner is only re-arbitrated in IDLE.
- Requests arriving mid-grant are latched and do not disturb the current grant.
- `busy`=1 in SETTLE, PULSE and HOLD.

## Timing
- All outputs are registered.
- Reset values: `sel`=0, `strobe`=0, `busy`=0, `ack`=0, `ovf`=0, `pending`=0, state IDLE.
- Reset asserted mid-grant:
  - `strobe` is low after the next edge.
  - No ack is issued.
  - All pending requests are discarded.
- Latency, with `req[i]` sampled at edge k and the scheduler idle:
  - `busy`=1 and `sel`=i after edge k+1.
  - `strobe`=1 after edge k+1+SETTLE_CYC.
  - `strobe`=0 after edge k+1+SETTLE_CYC+PULSE_CYC.
  - `ack[i]`=1 for one cycle after edge k+1+S+P+H.
- Back-to-back grants: the next grant is taken on the edge after the ack cycle. Minimum spacing is S+P+H+1 cycles.
- `en` falling during a grant: the grant completes normally, then the scheduler stays in IDLE with requests still latched.

## Configuration
- `STROBE_SCHED_TIMESTAMP_EN` defined:
  - Adds a free-running 32-bit cycle counter, reset to 0, which wraps modulo 2^32.
  - Adds output `ts` [31:0], which captures the counter value on the edge that sets `strobe`=1 and holds it until the next capture. Reset value is 0.
- Macro undefined: no counter and no `ts` port. All other behaviour is identical.

## Structure
- `strobe_sched_pkg` holds:
  - the `state_t` enum (IDLE, SETTLE, PULSE, HOLD);
  - the 32-bit timestamp width constant `TS_W`.
- Sub-module `rr_arbiter`: combinational round-robin pick with ports `pending`, `last`, `gnt_valid`, `gnt_idx`. The top level holds all state.

## Test plan
- Single request, defaults (S=2, P=1, H=1): `req[2]` at edge 0 → `sel`=2 and `busy` after edge 1; `strobe` high only between edges 3 and 4; `ack`=4'b0100 after edge 5.
- Simultaneous `req`=4'b1011 from reset → grants in order 0, 1, 3, one ack each, strobes spaced 5 cycles apart.
- Fairness: `req[0]` re-posted right after each of its acks while `req[1]` stays pending → grants alternate 0, 1, 0, 1.
- Overflow:
  - `req[1]` twice while pending → `ovf`=4'b0010, one ack only.
  - `req[1]` on `ack[1]`'s edge → no overflow, a second grant follows.
  - `ovf_clr` → `ovf`=0.
- Reset mid-PULSE → `strobe`=0, `busy`=0, `pending` cleared after the next edge, no ack.
- `en`=0 with `req[3]` latched → no grant. Raise `en` → `sel`=3 one edge later.
- With `STROBE_SCHED_TIMESTAMP_EN`: a first strobe from `req` at edge 0 → `ts`=3.
